pcileech_tx_arbiter: RTL and testbench

- Round-robin, packet-locked arbiter that shares the single 32-bit word path into the FT601 COM TX FIFO between up to NUM_REQ producers (TLP, CFG, core-status, loopback).
- Sits between the FIFO-control requesters and the COM controller's TX input.
- A grant is never broken mid-packet.
- A burst limit bounds how long one requester can hold the path across back-to-back packets.

---
 rtl/pcileech_arb_pkg.sv | 22 ++
 rtl/pcileech_rr_pick.sv | 24 ++
 rtl/pcileech_tx_arbiter.sv | 95 +++++++++
 tb/tb_pcileech_tx_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_arb_pkg.sv
// pcileech_arb_pkg: shared types and round-robin helper for the TX arbiter
//   arb_state_t : arbiter state encoding (IDLE / GRANT)
//   rr_pick     : one-hot winner among up to 8 request lanes, n lanes in use,
//                 searching upward from ptr with wrap-around
package pcileech_arb_pkg;
    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [7:0] win;
        int idx;
        win = '0;
        // scan from the farthest lane back to ptr so the closest request wins last
        for (int k = 7; k >= 0; k--) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && req[idx[2:0]]) win = 8'b1 << idx[2:0];
        end
        return win;
    endfunction
endpackage

// File: rtl/pcileech_rr_pick.sv
// pcileech_rr_pick: combinational round-robin picker
//   req   : request lanes
//   ptr   : lane with highest priority this round
//   grant : one-hot winner (zero when no request)
//   idx   : binary index of the winner
module pcileech_rr_pick import pcileech_arb_pkg::*; #(
    parameter int N = 3,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);
    logic [7:0] win;

    assign win   = rr_pick(8'(req), 3'(ptr), N);
    assign grant = win[N-1:0];

    always_comb begin
        idx = '0;
        for (int i = 0; i < 8; i++) if (win[i]) idx = W'(i);
    end
endmodule

// File: rtl/pcileech_tx_arbiter.sv
// pcileech_tx_arbiter: packet-locked round-robin arbiter feeding the FT601 COM TX path
//   clk, rst_n                    : clock, asynchronous active-low reset
//   req_valid/req_data/req_last   : per-requester word stream (requester i at [i*DATA_W +: DATA_W])
//   req_ready                     : per-requester accept
//   out_valid/out_data/out_last   : registered output word
//   out_src                       : requester that produced out_data
//   out_ready                     : downstream accept
//   busy                          : a grant is held
module pcileech_tx_arbiter import pcileech_arb_pkg::*; #(
    parameter int NUM_REQ   = 3,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready,
    output logic                      busy
);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    arb_state_t           state;
    logic [SRC_W-1:0]     grant_id, rr_ptr, pick_idx, next_ptr;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [BURST_W-1:0]   burst_cnt;
    logic                 pkt_end, grant_valid, hold, accept, budget_left;

    pcileech_rr_pick #(.N(NUM_REQ), .W(SRC_W)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign grant_valid = req_valid[grant_id];
    assign next_ptr    = (grant_id == SRC_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign budget_left = burst_cnt < BURST_W'(MAX_BURST - 1);
    // after a packet ends the grant only carries on if the same requester already shows its next word
    assign hold        = (state == ARB_GRANT) && (!pkt_end || grant_valid);
    assign req_ready   = (hold && (!out_valid || out_ready)) ? NUM_REQ'(1) << grant_id : '0;
    assign accept      = |(req_valid & req_ready);
    assign busy        = state == ARB_GRANT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            grant_id  <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            pkt_end   <= 1'b0;
        end else if (state == ARB_IDLE) begin
            if (|pick_grant) begin
                state     <= ARB_GRANT;
                grant_id  <= pick_idx;
                burst_cnt <= '0;
                pkt_end   <= 1'b0;
            end
        end else if (accept) begin
            burst_cnt <= (burst_cnt == BURST_W'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
            pkt_end   <= req_last[grant_id] && budget_left;
            if (req_last[grant_id] && !budget_left) begin
                state  <= ARB_IDLE;
                rr_ptr <= next_ptr;
            end
        end else if (pkt_end && !grant_valid) begin
            state   <= ARB_IDLE;
            rr_ptr  <= next_ptr;
            pkt_end <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= req_data[int'(grant_id) * DATA_W +: DATA_W];
            out_last  <= req_last[grant_id];
            out_src   <= grant_id;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pcileech_tx_arbiter.sv
// tb_pcileech_tx_arbiter: directed and randomized checks of the TX arbiter against per-source scoreboards
module tb_pcileech_tx_arbiter;
    localparam int N = 3, DW = 32, MB = 4, SW = 2;

    logic            clk = 0, rst_n = 1;
    logic [N-1:0]    req_valid = '0, req_last = '0, req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic            out_valid, out_last, out_ready = 1'b1, busy;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;

    pcileech_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_src(out_src), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0, vprob = 100, rdy_mode = 0, pushed = 0;
    logic [DW:0] send_q[N][$];
    logic [DW:0] exp_q[N][$];
    logic [N-1:0] acc = '0;
    int src_log[$], cyc_log[$];
    logic open_pkt = 0, stalled = 0;
    logic [SW-1:0] open_src = '0, stall_src = '0;
    logic [DW:0] stall_word = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // driver + monitor: inputs change at negedge, handshakes are evaluated 1 time unit later
    always @(negedge clk) begin : drv
        logic [DW:0] w;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(send_q[i].pop_front());
                req_valid[i] = 1'b0;
            end
            if (!req_valid[i] && send_q[i].size() > 0 && int'($urandom_range(99)) < vprob) begin
                req_valid[i] = 1'b1;
                {req_last[i], req_data[i*DW +: DW]} = send_q[i][0];
            end
        end
        out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(1)) :
                    ((cyc % 4 == 0) || (cyc % 4 == 3));
        #1;
        if (stalled) chk("stall_hold", {out_valid, out_src, out_last, out_data}, {1'b1, stall_src, stall_word});
        if (out_valid && !out_ready) chk("stall_ready", 64'(req_ready), 0);
        stalled    = out_valid && !out_ready;
        stall_word = {out_last, out_data};
        stall_src  = out_src;
        acc = req_valid & req_ready;
        if (out_valid && out_ready) begin
            if (open_pkt) chk("contiguous", 64'(out_src), 64'(open_src));
            chk("src_range", 64'(out_src < N), 1);
            if (out_src < N) begin
                chk("word_expected", 64'(exp_q[out_src].size() > 0), 1);
                if (exp_q[out_src].size() > 0) begin
                    w = exp_q[out_src].pop_front();
                    chk("word_order", 64'({out_last, out_data}), 64'(w));
                end
            end
            open_pkt = !out_last;
            open_src = out_src;
            src_log.push_back(int'(out_src));
            cyc_log.push_back(cyc);
        end
    end

    task automatic push_pkt(input int s, input int len, input logic [DW-1:0] base);
        for (int k = 0; k < len; k++) begin
            send_q[s].push_back({k == len - 1, base + DW'(k)});
            exp_q[s].push_back({k == len - 1, base + DW'(k)});
            pushed++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            send_q[i].delete();
            exp_q[i].delete();
        end
        req_valid = '0;
        acc = '0;
        open_pkt = 0;
        stalled = 0;
        src_log.delete();
        cyc_log.delete();
        pushed = 0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (send_q[i].size() > 0 || exp_q[i].size() > 0) return 1;
        return 0;
    endfunction

    task automatic wait_drain(input string tag, input int bound);
        int k = 0;
        while (k < bound && (pending() || out_valid || busy)) begin
            @(posedge clk);
            k++;
        end
        chk(tag, 64'(k < bound), 1);
        @(posedge clk); #1;
    endtask

    task automatic check_log(input string tag, input int exp[$]);
        chk({tag, "_len"}, 64'(src_log.size()), 64'(exp.size()));
        for (int j = 0; j < exp.size() && j < src_log.size(); j++)
            chk($sformatf("%s_src%0d", tag, j), 64'(src_log[j]), 64'(exp[j]));
    endtask

    initial begin : main
        int exp[$];
        int k;
        #3;
        do_reset();
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_out_last", 64'(out_last), 0);
        chk("rst_out_src", 64'(out_src), 0);
        chk("rst_req_ready", 64'(req_ready), 0);

        // single 4-word packet from requester 1: 2-cycle latency, then 1 word/cycle
        @(posedge clk); #1;
        push_pkt(1, 4, 32'hA0);
        @(negedge clk); #2;
        chk("t1_req_valid", 64'(req_valid[1]), 1);
        chk("t1_lat0", 64'(out_valid), 0);
        @(negedge clk); #2;
        chk("t1_lat1", 64'(out_valid), 0);
        chk("t1_busy", 64'(busy), 1);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk); #2;
            chk($sformatf("t1_valid%0d", j), 64'(out_valid), 1);
            chk($sformatf("t1_data%0d", j), 64'(out_data), 64'(32'hA0 + j));
            chk($sformatf("t1_src%0d", j), 64'(out_src), 1);
            chk($sformatf("t1_last%0d", j), 64'(out_last), 64'(j == 3));
        end
        chk("t1_busy_drop", 64'(busy), 0);
        wait_drain("t1_drain", 50);

        // all requesters stream 1-word packets: MB packets per grant, one idle cycle at each rotation
        do_reset();
        @(posedge clk); #1;
        for (int s = 0; s < N; s++) for (int j = 0; j < 8; j++) push_pkt(s, 1, DW'(s * 256 + j));
        wait_drain("t2_drain", 300);
        exp.delete();
        for (int j = 0; j < 24; j++) exp.push_back((j / MB) % N);
        check_log("t2", exp);
        for (int j = 1; j < 24 && j < cyc_log.size(); j++)
            chk($sformatf("t2_gap%0d", j), 64'(cyc_log[j] - cyc_log[j-1]), 64'((j % MB == 0) ? 2 : 1));

        // requester 0 streams 2-word packets while requester 2 waits
        do_reset();
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) push_pkt(0, 2, DW'(32'h1000 + j * 16));
        push_pkt(2, 2, 32'h2000);
        wait_drain("t3_drain", 200);
        exp = '{0, 0, 0, 0, 2, 2, 0, 0};
        check_log("t3", exp);

        // downstream stalls 1,0,0,1 mid-packet
        do_reset();
        rdy_mode = 2;
        @(posedge clk); #1;
        push_pkt(1, 8, 32'h3000);
        wait_drain("t4_drain", 200);
        exp = '{1, 1, 1, 1, 1, 1, 1, 1};
        check_log("t4", exp);
        rdy_mode = 0;

        // a 20-word packet exceeds the burst limit but is never interrupted
        do_reset();
        @(posedge clk); #1;
        push_pkt(0, 20, 32'h4000);
        push_pkt(1, 2, 32'h5000);
        push_pkt(2, 2, 32'h6000);
        wait_drain("t5_drain", 300);
        exp.delete();
        for (int j = 0; j < 20; j++) exp.push_back(0);
        exp.push_back(1); exp.push_back(1); exp.push_back(2); exp.push_back(2);
        check_log("t5", exp);

        // reset in the middle of a 5-word packet, then requester 2 alone
        do_reset();
        @(posedge clk); #1;
        push_pkt(0, 5, 32'h7000);
        k = 0;
        while (k < 50 && src_log.size() < 2) begin
            @(negedge clk); #2;
            k++;
        end
        chk("t6_partial", 64'(src_log.size()), 2);
        chk("t6_mid_valid", 64'(out_valid), 1);
        do_reset();
        @(posedge clk); #1;
        push_pkt(2, 2, 32'h8000);
        wait_drain("t6_drain", 100);
        exp = '{2, 2};
        check_log("t6", exp);

        // randomized traffic with random backpressure and request gaps
        do_reset();
        rdy_mode = 1;
        vprob = 60;
        @(posedge clk); #1;
        for (int p = 0; p < 60; p++) push_pkt(int'($urandom_range(N - 1)), int'($urandom_range(6, 1)), DW'($urandom));
        k = pushed;
        wait_drain("rand_drain", 5000);
        chk("rand_count", 64'(src_log.size()), 64'(k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
